// File: rtl/dual_branch_predictor_if.sv
// Fetch/execute bundle between the two-wide pipeline and the dual branch predictor.
// The pipeline side uses the master modport; the predictor uses the slave modport.
interface dual_branch_predictor_if #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
);
  // Fetch-stage lookup, slot 1 is the older instruction
  logic [PC_WIDTH-1:0]   pcF1;
  logic [PC_WIDTH-1:0]   pcF2;
  logic                  predictionF1;
  logic                  predictionF2;
  logic [INDEX_BITS-1:0] indexF1;
  logic [INDEX_BITS-1:0] indexF2;

  // Execute-stage resolution feedback
  logic                  branchE1;
  logic                  branchE2;
  logic [INDEX_BITS-1:0] indexE1;
  logic [INDEX_BITS-1:0] indexE2;
  logic                  takenE1;
  logic                  takenE2;
  logic                  predictionE1;
  logic                  predictionE2;

  // Statistics
  logic [CNT_WIDTH-1:0]  mispredCount;

  modport master (
    output pcF1, pcF2,
    output branchE1, branchE2, indexE1, indexE2,
    output takenE1, takenE2, predictionE1, predictionE2,
    input  predictionF1, predictionF2, indexF1, indexF2,
    input  mispredCount
  );

  modport slave (
    input  pcF1, pcF2,
    input  branchE1, branchE2, indexE1, indexE2,
    input  takenE1, takenE2, predictionE1, predictionE2,
    output predictionF1, predictionF2, indexF1, indexF2,
    output mispredCount
  );
endinterface

// File: rtl/dual_branch_predictor.sv
// Dual-ported bimodal branch predictor: two combinational lookups per cycle,
// two training updates per cycle into a table of 2-bit saturating counters,
// plus a saturating misprediction counter.
// Optional macro GSHARE_EN: adds a non-speculative global history register
// that is XORed into both lookup indices (gshare). Undefined = pure bimodal.
module dual_branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  dual_branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // One saturating step of a 2-bit counter toward taken / not-taken
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    if (taken) r = (c == 2'b11) ? 2'b11 : c + 2'b01;
    else       r = (c == 2'b00) ? 2'b00 : c - 2'b01;
    return r;
  endfunction

  // Flattened read view of the counter table for the combinational lookups
  logic [1:0] table_rd [ENTRIES];

  // Each counter owns its own flop; slot 1 is applied before slot 2 so a
  // same-index dual update behaves like two sequential updates.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic [1:0] cnt_q;
    logic [1:0] cnt_mid;
    logic [1:0] cnt_d;

    // Next counter value: slot 1 update, then slot 2 update on the result
    always_comb begin
      cnt_mid = cnt_q;
      if (bp.branchE1 && (bp.indexE1 == INDEX_BITS'(gi)))
        cnt_mid = sat_step(cnt_q, bp.takenE1);
      cnt_d = cnt_mid;
      if (bp.branchE2 && (bp.indexE2 == INDEX_BITS'(gi)))
        cnt_d = sat_step(cnt_mid, bp.takenE2);
    end

    // Counter register, reset to weakly not-taken
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= 2'b01;
      else       cnt_q <= cnt_d;
    end

    assign table_rd[gi] = cnt_q;
  end

`ifdef GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;
  logic [INDEX_BITS-1:0] ghr_d;

  // History shift: two outcomes when both slots resolve (slot 1 older), one otherwise
  always_comb begin
    ghr_d = ghr_q;
    case ({bp.branchE1, bp.branchE2})
      2'b11:   ghr_d = {ghr_q[INDEX_BITS-3:0], bp.takenE1, bp.takenE2};
      2'b10:   ghr_d = {ghr_q[INDEX_BITS-2:0], bp.takenE1};
      2'b01:   ghr_d = {ghr_q[INDEX_BITS-2:0], bp.takenE2};
      default: ghr_d = ghr_q;
    endcase
  end

  // Global history register, committed from resolved branches only
  always_ff @(posedge clk) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  // Lookup index: PC low bits hashed with the shared history
  always_comb begin
    bp.indexF1 = bp.pcF1[INDEX_BITS-1:0] ^ ghr_q;
    bp.indexF2 = bp.pcF2[INDEX_BITS-1:0] ^ ghr_q;
  end
`else
  // Lookup index: PC low bits only
  always_comb begin
    bp.indexF1 = bp.pcF1[INDEX_BITS-1:0];
    bp.indexF2 = bp.pcF2[INDEX_BITS-1:0];
  end
`endif

  // Prediction is the counter MSB; reads see the pre-update table (no bypass)
  always_comb begin
    bp.predictionF1 = table_rd[bp.indexF1][1];
    bp.predictionF2 = table_rd[bp.indexF2][1];
  end

  // Upper PC bits do not take part in indexing
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pcF1[PC_WIDTH-1:INDEX_BITS], bp.pcF2[PC_WIDTH-1:INDEX_BITS]};

  logic [CNT_WIDTH-1:0] mispred_q;
  logic [CNT_WIDTH-1:0] mispred_d;
  logic [1:0]           mispred_inc;
  logic [CNT_WIDTH:0]   mispred_sum;

  // Add 0..2 mispredictions per cycle, clamping at all-ones
  always_comb begin
    mispred_inc = {1'b0, bp.branchE1 & (bp.takenE1 ^ bp.predictionE1)}
                + {1'b0, bp.branchE2 & (bp.takenE2 ^ bp.predictionE2)};
    mispred_sum = {1'b0, mispred_q} + {{(CNT_WIDTH - 1){1'b0}}, mispred_inc};
    mispred_d   = mispred_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : mispred_sum[CNT_WIDTH-1:0];
  end

  // Misprediction statistics register
  always_ff @(posedge clk) begin
    if (reset) mispred_q <= '0;
    else       mispred_q <= mispred_d;
  end

  assign bp.mispredCount = mispred_q;

endmodule

// File: tb/tb_dual_branch_predictor.sv
// Directed scoreboard bench for dual_branch_predictor. Stimulus drives one
// cycle at a time and queues the outputs expected during that cycle; the
// monitor compares on the falling edge.
module tb_dual_branch_predictor;

  localparam int IB = 6;
  localparam int PW = 32;
  localparam int CW = 16;

  logic clk;
  logic reset;

  dual_branch_predictor_if #(.INDEX_BITS(IB), .PC_WIDTH(PW), .CNT_WIDTH(CW)) bp_if ();

  dual_branch_predictor #(.INDEX_BITS(IB), .PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          pred1;
    logic          pred2;
    logic [IB-1:0] idx1;
    logic [IB-1:0] idx2;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s got %0d expected %0d", name, field, act, req);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("[TB] %s pred=%b%b idx=%0d,%0d cnt=%0d", e.name,
               bp_if.predictionF1, bp_if.predictionF2, bp_if.indexF1, bp_if.indexF2, bp_if.mispredCount);
      chk(e.name, "predictionF1", 32'(bp_if.predictionF1), 32'(e.pred1));
      chk(e.name, "predictionF2", 32'(bp_if.predictionF2), 32'(e.pred2));
      chk(e.name, "indexF1", 32'(bp_if.indexF1), 32'(e.idx1));
      chk(e.name, "indexF2", 32'(bp_if.indexF2), 32'(e.idx2));
      chk(e.name, "mispredCount", 32'(bp_if.mispredCount), 32'(e.cnt));
    end
  end

  task automatic drive(input logic [PW-1:0] pc1, input logic [PW-1:0] pc2,
                       input logic b1, input logic [IB-1:0] i1, input logic t1, input logic p1,
                       input logic b2, input logic [IB-1:0] i2, input logic t2, input logic p2);
    bp_if.pcF1 = pc1;          bp_if.pcF2 = pc2;
    bp_if.branchE1 = b1;       bp_if.indexE1 = i1;
    bp_if.takenE1 = t1;        bp_if.predictionE1 = p1;
    bp_if.branchE2 = b2;       bp_if.indexE2 = i2;
    bp_if.takenE2 = t2;        bp_if.predictionE2 = p2;
  endtask

  task automatic expect_now(input string name, input logic pr1, input logic pr2,
                            input logic [IB-1:0] ix1, input logic [IB-1:0] ix2, input logic [CW-1:0] c);
    exp_t e;
    e.name = name; e.pred1 = pr1; e.pred2 = pr2; e.idx1 = ix1; e.idx2 = ix2; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    drive(4, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("reset_state", 0, 0, 4, 5, 0);
    step();

    // Dual taken resolution: bimodal index vs gshare-hashed index
    drive(0, 1, 1, 9, 1, 1, 1, 10, 1, 1);
    expect_now("dual_resolve", 0, 0, 0, 1, 0);
    step();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef GSHARE_EN
    expect_now("ghr_index", 0, 0, 3, 2, 0);
`else
    expect_now("ghr_index", 0, 0, 0, 1, 0);
`endif
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;

`ifndef GSHARE_EN
    // Two taken updates on entry 5: 01 -> 10 -> 11, both mispredicted
    drive(5, 6, 1, 5, 1, 0, 0, 0, 0, 0);
    expect_now("train5_a", 0, 0, 5, 6, 0);
    step();
    expect_now("train5_b", 1, 0, 5, 6, 1);
    step();
    drive(5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("train5_done", 1, 0, 5, 6, 2);
    step();

    // Same-index dual update T,T on entry 7: 01 -> 11
    drive(7, 7, 1, 7, 1, 1, 1, 7, 1, 1);
    expect_now("dual7_tt", 0, 0, 7, 7, 2);
    step();
    drive(7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("dual7_after", 1, 1, 7, 7, 2);
    step();

    // Same-index dual update T,NT on entry 8: stays 01
    drive(8, 7, 1, 8, 1, 1, 1, 8, 0, 0);
    expect_now("dual8_tnt", 0, 1, 8, 7, 2);
    step();
    // One more taken proves entry 8 was still 01 (now 10)
    drive(8, 7, 1, 8, 1, 0, 0, 0, 0, 0);
    expect_now("dual8_probe", 0, 1, 8, 7, 2);
    step();
    drive(8, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("dual8_after", 1, 1, 8, 7, 3);
    step();

    // Four not-taken updates on entry 2 saturate at 00, no mispredicts
    for (int k = 0; k < 4; k++) begin
      drive(2, 2, 0, 0, 0, 0, 1, 2, 0, 0);
      expect_now($sformatf("nt2_%0d", k), 0, 0, 2, 2, 3);
      step();
    end
    // Two taken updates: 00 -> 01 -> 10, prediction flips only after the second
    drive(2, 2, 1, 2, 1, 1, 0, 0, 0, 0);
    expect_now("sat2_up1", 0, 0, 2, 2, 3);
    step();
    expect_now("sat2_up2", 0, 0, 2, 2, 3);
    step();
    drive(2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("sat2_after", 1, 1, 2, 2, 3);
    step();

    // Train entry 3 to 11 then reset with a pending update
    drive(3, 4, 1, 3, 1, 1, 0, 0, 0, 0);
    expect_now("train3_a", 0, 0, 3, 4, 3);
    step();
    expect_now("train3_b", 1, 0, 3, 4, 3);
    step();
    reset = 1'b1;
    drive(3, 4, 1, 3, 1, 0, 0, 0, 0, 0);
    expect_now("reset_pending", 1, 0, 3, 4, 3);
    step();
    reset = 1'b0;
    drive(3, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("after_reset", 0, 0, 3, 5, 0);
    step();

    // Independent dual update to different indices, both mispredicted
    drive(10, 11, 1, 10, 1, 0, 1, 11, 0, 1);
    expect_now("indep_upd", 0, 0, 10, 11, 0);
    step();
    drive(10, 11, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("indep_after", 1, 0, 10, 11, 2);
    step();

    // Drive mispredCount from 2 up to max-1 with dual mispredicts
    drive(20, 21, 1, 20, 1, 0, 1, 21, 0, 1);
    repeat (32766) @(posedge clk);
    #1;
    expect_now("cnt_max_m1", 1, 0, 20, 21, 16'hFFFE);
    step();
    expect_now("cnt_max", 1, 0, 20, 21, 16'hFFFF);
    step();
    drive(20, 21, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("cnt_hold", 1, 0, 20, 21, 16'hFFFF);
    step();
`endif

    // Let the monitor drain, bounded
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) step();
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
